fetch_ctrl: RTL and testbench

//   Sequences the instruction-fetch datapath. Owns the PC and issues one-outstanding req/gnt/rvalid reads
//   to instruction memory. Holds fetched {pc, inst} in an output register plus a 1-entry skid buffer, so
//   a decode stall never loses a word. Handles branch/jump redirects, discarding stale in-flight fetches.

---
 rtl/cqu_mips_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cqu_mips_pkg.sv
// Shared fetch-unit types and constants.
// Fetch FSM states, reset PC default and the NOP word.
package cqu_mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} skid buffer for the fetch output stage.
// Flush wins over load; load wins over unload.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        load,
  input  logic        unload,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      inst  <= in_inst;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, one-outstanding imem reads, output reg + skid.
// FETCH_ALIGN_CHK_EN: misaligned redirect targets raise if_exc_o (ERR state).
module fetch_ctrl
  import cqu_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_exc_o
);

  fetch_state_e state, nxt;
  logic [31:0] pc, req_pc, tgt;
  logic        drop;
  logic        mis, grant, wait_busy;
  logic        consume, out_free, resp;
  logic        sk_valid, sk_load, sk_unload;
  logic [31:0] sk_pc, sk_inst;

  assign tgt       = redirect_pc_i & 32'hFFFF_FFFC;
  assign grant     = imem_req_o && imem_gnt_i;
  assign wait_busy = (state == WAIT) && !imem_rvalid_i;
  assign consume   = if_valid_o && !stall_i;
  assign out_free  = !if_valid_o || !stall_i;
  assign resp      = (state == WAIT) && imem_rvalid_i && !drop
                  && !redirect_i;
  assign sk_load   = resp && !out_free;
  assign sk_unload = (state == HOLD) && consume && !redirect_i;

`ifdef FETCH_ALIGN_CHK_EN
  assign mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = REQ;
      REQ:  if (grant) nxt = WAIT;
      WAIT: if (imem_rvalid_i)
              nxt = (drop || out_free) ? REQ : HOLD;
      HOLD: if (consume) nxt = REQ;
      ERR:  nxt = ERR;
      default: nxt = IDLE;
    endcase
    if (redirect_i) begin
      priority case (1'b1)
        mis:       nxt = ERR;
        grant:     nxt = WAIT;
        wait_busy: nxt = WAIT;
        default:   nxt = REQ;
      endcase
    end
  end

  // drop gates the request so a stale response never overlaps a new one
  always_comb begin
    imem_req_o  = (state == REQ) && !drop;
    imem_addr_o = imem_req_o ? pc : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= drop && !imem_rvalid_i;
      if (redirect_i) begin
        pc <= tgt;
        if (grant || wait_busy) drop <= 1'b1;
      end else if (grant) begin
        req_pc <= pc;
        pc     <= pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
    end else if (redirect_i) begin
      if_valid_o <= mis;
`ifdef FETCH_ALIGN_CHK_EN
      if (mis) begin
        if_pc_o   <= redirect_pc_i;
        if_inst_o <= NOP_WORD;
      end
`endif
    end else if (sk_unload) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= sk_pc;
      if_inst_o  <= sk_inst;
    end else if (resp && out_free) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= req_pc;
      if_inst_o  <= imem_rdata_i;
    end else if (consume && state != ERR) begin
      if_valid_o <= 1'b0;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        if_exc_o <= 1'b0;
    else if (redirect_i)              if_exc_o <= mis;
    else if (sk_unload || resp)       if_exc_o <= 1'b0;
  end
`else
  assign if_exc_o = 1'b0;
`endif

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (redirect_i),
    .load    (sk_load),
    .unload  (sk_unload),
    .in_pc   (req_pc),
    .in_inst (imem_rdata_i),
    .valid   (sk_valid),
    .pc      (sk_pc),
    .inst    (sk_inst)
  );

  logic unused;
  assign unused = sk_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable imem model.
// Expectations cover both FETCH_ALIGN_CHK_EN settings.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, redirect;
  logic [31:0] rpc;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        vld, exc;
  logic [31:0] ipc, inst;

  logic        gnt_en;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .if_valid_o    (vld),
    .if_pc_o       (ipc),
    .if_inst_o     (inst),
    .if_exc_o      (exc)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  assign gnt = req && gnt_en;

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        rvalid <= 1'b1;
        rdata  <= mem(paddr);
        pend   <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (req && gnt) begin
      if (lat == 0) begin
        rvalid <= 1'b1;
        rdata  <= mem(addr);
      end else begin
        pend  <= 1'b1;
        paddr <= addr;
        cnt   <= lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] t5;

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = '0;
    gnt_en = 1'b1; lat = 0; pend = 1'b0; cnt = 0;
    rvalid = 1'b0; rdata = '0; paddr = '0;
    tick(2);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_pc", ipc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_exc", {31'b0, exc}, 32'd0);
    rstn = 1'b1;

    // 1: sequential fetch
    tick();
    chk("t1_req0", {31'b0, req}, 32'd1);
    chk("t1_addr0", addr, 32'h0);
    tick(2);
    chk("t1_vld0", {31'b0, vld}, 32'd1);
    chk("t1_pc0", ipc, 32'h0);
    chk("t1_inst0", inst, mem(32'h0));
    chk("t1_addr4", addr, 32'h4);
    tick(2);
    chk("t1_pc4", ipc, 32'h4);
    chk("t1_inst4", inst, mem(32'h4));
    chk("t1_addr8", addr, 32'h8);

    // 2: stall holds output, second word parks in skid
    stall = 1'b1;
    tick(2);
    chk("t2_noreq_a", {31'b0, req}, 32'd0);
    chk("t2_pc_a", ipc, 32'h4);
    tick(3);
    chk("t2_noreq_b", {31'b0, req}, 32'd0);
    chk("t2_pc_b", ipc, 32'h4);
    chk("t2_vld_b", {31'b0, vld}, 32'd1);
    tick();
    stall = 1'b0;
    tick();
    chk("t2_pc8", ipc, 32'h8);
    chk("t2_inst8", inst, mem(32'h8));
    chk("t2_addr12", addr, 32'hC);

    // 3: redirect while WAIT, response still pending
    lat = 2;
    tick();
    chk("t3_wait", {31'b0, req}, 32'd0);
    redirect = 1'b1; rpc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_vld", {31'b0, vld}, 32'd0);
    chk("t3_noreq", {31'b0, req}, 32'd0);
    tick(2);
    chk("t3_req", {31'b0, req}, 32'd1);
    chk("t3_addr", addr, 32'h100);
    chk("t3_vld2", {31'b0, vld}, 32'd0);
    lat = 0;
    tick(2);
    chk("t3_pc", ipc, 32'h100);
    chk("t3_inst", inst, mem(32'h100));
    chk("t3_addr104", addr, 32'h104);

    // 4: redirect with gnt, then with rvalid
    redirect = 1'b1; rpc = 32'h200;
    tick();
    rpc = 32'h300;
    chk("t4_vld_a", {31'b0, vld}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("t4_addr", addr, 32'h300);
    chk("t4_vld_b", {31'b0, vld}, 32'd0);
    tick(2);
    chk("t4_pc300", ipc, 32'h300);
    chk("t4_inst300", inst, mem(32'h300));
    tick();
    redirect = 1'b1; rpc = 32'h400;
    tick();
    redirect = 1'b0;
    chk("t4_vld_c", {31'b0, vld}, 32'd0);
    chk("t4_addr400", addr, 32'h400);
    tick(2);
    chk("t4_pc400", ipc, 32'h400);

    // 5: wrap at top of address space, withdrawn request
    redirect = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("t5_addr_top", addr, 32'hFFFF_FFFC);
    tick(2);
    chk("t5_pc_top", ipc, 32'hFFFF_FFFC);
    chk("t5_inst_top", inst, mem(32'hFFFF_FFFC));
    chk("t5_addr_wrap", addr, 32'h0);
    gnt_en = 1'b0;
    tick();
    chk("t5_hold_req", {31'b0, req}, 32'd1);
    chk("t5_hold_addr", addr, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    t5 = 32'h500;
`else
    t5 = 32'h503;
`endif
    redirect = 1'b1; rpc = t5;
    tick();
    redirect = 1'b0;
    chk("t5_addr500", addr, 32'h500);
    chk("t5_vld", {31'b0, vld}, 32'd0);
    gnt_en = 1'b1;
    tick(2);
    chk("t5_pc500", ipc, 32'h500);
    chk("t5_exc", {31'b0, exc}, 32'd0);

`ifdef FETCH_ALIGN_CHK_EN
    // 6: misaligned redirect parks in ERR
    redirect = 1'b1; rpc = 32'h102;
    tick();
    redirect = 1'b0;
    chk("t6_exc", {31'b0, exc}, 32'd1);
    chk("t6_vld", {31'b0, vld}, 32'd1);
    chk("t6_pc", ipc, 32'h102);
    chk("t6_inst", inst, 32'h0);
    chk("t6_noreq", {31'b0, req}, 32'd0);
    stall = 1'b1;
    tick(2);
    chk("t6_exc_st", {31'b0, exc}, 32'd1);
    chk("t6_noreq_st", {31'b0, req}, 32'd0);
    stall = 1'b0;
    tick(2);
    chk("t6_exc_hold", {31'b0, exc}, 32'd1);
    chk("t6_pc_hold", ipc, 32'h102);
    redirect = 1'b1; rpc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("t6_exc_clr", {31'b0, exc}, 32'd0);
    chk("t6_vld_clr", {31'b0, vld}, 32'd0);
    chk("t6_addr200", addr, 32'h200);
`else
    tick(2);
    chk("t6_exc0", {31'b0, exc}, 32'd0);
`endif

    // async reset mid-transaction
    tick(2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", {31'b0, vld}, 32'd0);
    chk("arst_req", {31'b0, req}, 32'd0);
    chk("arst_pc", ipc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
